// File: rtl/lsm_pkg.sv
// rtl/lsm_pkg.sv - opcode encodings and FSM state type for the LSM accumulator CPU
package lsm_pkg;

   localparam logic [2:0] OP_IN  = 3'b000;
   localparam logic [2:0] OP_OUT = 3'b001;
   localparam logic [2:0] OP_ST  = 3'b010;
   localparam logic [2:0] OP_LD  = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_JMP = 3'b101;
   localparam logic [2:0] OP_JZ  = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   typedef enum logic [2:0] {
      S_RST,
      S_IF1,
      S_IF2,
      S_ID,
      S_EX,
      S_HALT
   } state_t;

endpackage

// File: rtl/lsm_alu.sv
// rtl/lsm_alu.sv - combinational adder with carry-out and zero flag on operand a
module lsm_alu #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   output logic [DW-1:0] o_sum,
   output logic          o_c,
   output logic          o_zero
);

   assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, i_b};
   assign o_zero       = (i_a == '0);

endmodule

// File: rtl/lsm_cpu.sv
// rtl/lsm_cpu.sv - accumulator CPU fetching from ROM and accessing RAM over one tristate bus
// Define LSM_WAIT_EN to add the mem_rdy port and stretch IF2/EX with wait states.
module lsm_cpu
   import lsm_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   inout  wire  [DW-1:0] dr,
   output logic [AW:0]   ar,
   output logic          rd,
   output logic          wr,
   input  logic [DW-1:0] buf_in,
   output logic [DW-1:0] buf_out,
   output logic          halted
`ifdef LSM_WAIT_EN
   ,
   input  logic          mem_rdy
`endif
);

   if (AW > DW - 3) begin : g_aw_check
      $error("lsm_cpu: AW must not exceed DW-3");
   end

   state_t          r_state, w_state_nxt;
   logic [AW-1:0]   r_pc, w_pc_nxt;
   logic [DW-1:0]   r_acc, w_acc_nxt;
   logic [AW+2:0]   r_ir, w_ir_nxt;
   logic            r_c, w_c_nxt;
   logic [AW:0]     r_ar, w_ar_nxt;
   logic            r_rd, w_rd_nxt;
   logic            r_wr, w_wr_nxt;
   logic [DW-1:0]   r_buf_out, w_buf_out_nxt;
   logic            r_halted, w_halted_nxt;

   logic            w_rdy;
   logic [2:0]      w_op, w_dr_op;
   logic [AW-1:0]   w_a, w_dr_a;
   logic [DW-1:0]   w_alu_sum;
   logic            w_alu_c;
   logic            w_acc_zero;

`ifdef LSM_WAIT_EN
   assign w_rdy = mem_rdy;
`else
   assign w_rdy = 1'b1;
`endif

   // ir keeps only the opcode and operand fields of the fetched word
   assign w_op    = r_ir[AW+2:AW];
   assign w_a     = r_ir[AW-1:0];
   assign w_dr_op = dr[DW-1:DW-3];
   assign w_dr_a  = dr[AW-1:0];

   lsm_alu #(.DW(DW)) u_alu (
      .i_a    (r_acc),
      .i_b    (dr),
      .o_sum  (w_alu_sum),
      .o_c    (w_alu_c),
      .o_zero (w_acc_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_RST;
         r_pc      <= '0;
         r_acc     <= '0;
         r_ir      <= '0;
         r_c       <= 1'b0;
         r_ar      <= '0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_buf_out <= '0;
         r_halted  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_acc     <= w_acc_nxt;
         r_ir      <= w_ir_nxt;
         r_c       <= w_c_nxt;
         r_ar      <= w_ar_nxt;
         r_rd      <= w_rd_nxt;
         r_wr      <= w_wr_nxt;
         r_buf_out <= w_buf_out_nxt;
         r_halted  <= w_halted_nxt;
      end
   end

   // Bus outputs are registered for the state being entered, so each state's strobes are live during it
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_acc_nxt     = r_acc;
      w_ir_nxt      = r_ir;
      w_c_nxt       = r_c;
      w_ar_nxt      = r_ar;
      w_rd_nxt      = r_rd;
      w_wr_nxt      = r_wr;
      w_buf_out_nxt = r_buf_out;
      w_halted_nxt  = r_halted;
      case (r_state)
         S_RST: w_state_nxt = S_IF1;
         S_IF1: begin
            w_state_nxt = S_IF2;
            w_rd_nxt    = 1'b0;
         end
         S_IF2: begin
            if (w_rdy) begin
               w_ir_nxt    = {w_dr_op, w_dr_a};
               w_pc_nxt    = r_pc + AW'(1);
               w_state_nxt = S_ID;
               if (w_dr_op == OP_LD || w_dr_op == OP_ADD || w_dr_op == OP_ST) begin
                  w_ar_nxt = {1'b0, w_dr_a};
                  w_rd_nxt = (w_dr_op != OP_ST);
               end
            end
         end
         S_ID: begin
            w_state_nxt = S_IF1;
            case (w_op)
               OP_IN:  w_acc_nxt = buf_in;
               OP_OUT: w_buf_out_nxt = r_acc;
               OP_JMP: w_pc_nxt = w_a;
               OP_JZ: begin
                  if (w_acc_zero) w_pc_nxt = w_a;
               end
               OP_HLT: begin
                  w_halted_nxt = 1'b1;
                  w_state_nxt  = S_HALT;
                  w_rd_nxt     = 1'b0;
                  w_wr_nxt     = 1'b0;
               end
               OP_ST: begin
                  w_state_nxt = S_EX;
                  w_wr_nxt    = 1'b1;
               end
               default: begin
                  w_state_nxt = S_EX;
                  w_rd_nxt    = 1'b0;
               end
            endcase
         end
         S_EX: begin
            if (w_rdy) begin
               w_state_nxt = S_IF1;
               if (w_op == OP_LD) begin
                  w_acc_nxt = dr;
               end else if (w_op == OP_ADD) begin
                  w_acc_nxt = w_alu_sum;
                  w_c_nxt   = w_alu_c;
               end
            end
         end
         S_HALT: begin
            w_rd_nxt = 1'b0;
            w_wr_nxt = 1'b0;
         end
         default: w_state_nxt = S_RST;
      endcase
      // Every entry into IF1 presents the (possibly jumped) pc to the ROM
      if (w_state_nxt == S_IF1) begin
         w_ar_nxt = {1'b1, w_pc_nxt};
         w_rd_nxt = 1'b1;
         w_wr_nxt = 1'b0;
      end
   end

   assign dr      = r_wr ? r_acc : 'z;
   assign ar      = r_ar;
   assign rd      = r_rd;
   assign wr      = r_wr;
   assign buf_out = r_buf_out;
   assign halted  = r_halted;

endmodule
